// File: rtl/jtdd_rom_rd.sv
// Video ROM fetch responder for the char and scroll layers.
// Both clients share one 16-bit SDRAM read port. Each client has a one-word
// cache, and its ok output is high only while the cached tag matches the
// address that client is presenting now.
module jtdd_rom_rd #(
  parameter logic [21:0] CHAR_OFFSET = 22'h00000,
  parameter logic [21:0] SCR_OFFSET  = 22'h08000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [14:0] char_addr,
  output logic [7:0]  char_data,
  output logic        char_ok,
  input  logic [16:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [15:0] sdram_data
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  localparam logic SLOT_CHAR = 1'b0;
  localparam logic SLOT_SCR  = 1'b1;

  // Fetch engine state
  state_t      r_state;
  logic        r_slot;
  logic [16:0] r_pend_tag;
  logic [21:0] r_sdram_addr;
  logic        r_sdram_req;

  // Per-client caches
  logic [13:0] r_char_tag;
  logic [15:0] r_char_word;
  logic        r_char_valid;
  logic [16:0] r_scr_tag;
  logic [15:0] r_scr_word;
  logic        r_scr_valid;

  // Next-state values
  state_t      w_state_nxt;
  logic        w_slot_nxt;
  logic [16:0] w_pend_tag_nxt;
  logic [21:0] w_sdram_addr_nxt;
  logic        w_sdram_req_nxt;
  logic        w_fill;

  logic        w_char_ok;
  logic        w_scr_ok;
  logic        w_char_fill;
  logic        w_scr_fill;

  // Hit detection compares against the live client address, so ok drops in
  // the same cycle the address moves to another tag.
  assign w_char_ok = r_char_valid & (r_char_tag == char_addr[14:1]);
  assign w_scr_ok  = r_scr_valid  & (r_scr_tag  == scr_addr);

  assign char_ok    = w_char_ok;
  assign scr_ok     = w_scr_ok;
  assign char_data  = char_addr[0] ? r_char_word[15:8] : r_char_word[7:0];
  assign scr_data   = r_scr_word;
  assign sdram_addr = r_sdram_addr;
  assign sdram_req  = r_sdram_req;

  assign w_char_fill = w_fill & (r_slot == SLOT_CHAR);
  assign w_scr_fill  = w_fill & (r_slot == SLOT_SCR);

  // Next-state logic: pick a missing client (char first), then walk the
  // request/ack/data handshake. Requests are never aborted.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    w_state_nxt      = r_state;
    w_slot_nxt       = r_slot;
    w_pend_tag_nxt   = r_pend_tag;
    w_sdram_addr_nxt = r_sdram_addr;
    w_sdram_req_nxt  = r_sdram_req;
    w_fill           = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_char_ok) begin
          w_pend_tag_nxt   = {3'd0, char_addr[14:1]};
          w_sdram_addr_nxt = CHAR_OFFSET + {8'd0, char_addr[14:1]};
          w_slot_nxt       = SLOT_CHAR;
          w_sdram_req_nxt  = 1'b1;
          w_state_nxt      = WAIT_ACK;
        end else if (!w_scr_ok) begin
          w_pend_tag_nxt   = scr_addr;
          w_sdram_addr_nxt = SCR_OFFSET + {5'd0, scr_addr};
          w_slot_nxt       = SLOT_SCR;
          w_sdram_req_nxt  = 1'b1;
          w_state_nxt      = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          w_sdram_req_nxt = 1'b0;
          // Data returning alongside the ack completes the fetch at once.
          if (sdram_dst) begin
            w_fill      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (sdram_dst) begin
          w_fill      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_sdram_req_nxt = 1'b0;
        w_state_nxt     = IDLE;
      end
    endcase
  end

  // Fetch engine registers; reset drops the request asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_slot       <= SLOT_CHAR;
      r_pend_tag   <= '0;
      r_sdram_addr <= '0;
      r_sdram_req  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state      <= w_state_nxt;
      r_slot       <= w_slot_nxt;
      r_pend_tag   <= w_pend_tag_nxt;
      r_sdram_addr <= w_sdram_addr_nxt;
      r_sdram_req  <= w_sdram_req_nxt;
    end
  end

  // Cache fill: the returned word is stored under the tag latched at request
  // time, even if the client has since moved on.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: cache words are reset too, so char_data/scr_data read 0 out of reset rather than X.
      r_char_tag   <= '0;
      r_char_word  <= '0;
      r_char_valid <= 1'b0;
      r_scr_tag    <= '0;
      r_scr_word   <= '0;
      r_scr_valid  <= 1'b0;
    end else begin
      if (w_char_fill) begin
        r_char_tag   <= r_pend_tag[13:0];
        r_char_word  <= sdram_data;
        r_char_valid <= 1'b1;
      end
      if (w_scr_fill) begin
        r_scr_tag    <= r_pend_tag;
        r_scr_word   <= sdram_data;
        r_scr_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/jtdd_rom_rd.md
Name: jtdd_rom_rd

Overview:
- Responder side of the video ROM fetch handshake (addr in, data + ok out) used by the char and scroll layers.
- Serves both clients from one 16-bit SDRAM read port.
- Keeps a one-word cache per client and raises ok only when the returned data matches the address the client is presenting now.
- Sits between the video top level and the SDRAM controller.

Parameters:
- CHAR_OFFSET, 22'h00000, SDRAM word base address of the char ROM
- SCR_OFFSET, 22'h08000, SDRAM word base address of the scroll ROM

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; asynchronous assertion, active-low
- char_addr  in  15  char ROM byte address from the char layer
- char_data  out  8  char ROM byte
- char_ok  out  1  char_data is valid for the current char_addr
- scr_addr  in  17  scroll ROM word address
- scr_data  out  16  scroll ROM word
- scr_ok  out  1  scr_data is valid for the current scr_addr
- sdram_addr  out  22  SDRAM word address
- sdram_req  out  1  read request, level
- sdram_ack  in  1  one-cycle pulse: request accepted
- sdram_dst  in  1  one-cycle pulse: sdram_data valid
- sdram_data  in  16  SDRAM read word

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low (rstn=0).
- Values held during reset:
  - sdram_req=0, sdram_addr=0, state=IDLE
  - both cache valid bits=0, cache tags=0, cache data=0
  - char_ok=0, scr_ok=0, char_data=0, scr_data=0
- Per-slot cache: tag, data word, valid bit.
  - Char tag = char_addr[14:1]. Scroll tag = scr_addr[16:0].
- Outputs are combinational from the cache:
  - char_ok = char_valid & (char_tag == char_addr[14:1]).
  - scr_ok = scr_valid & (scr_tag == scr_addr).
  - char_data = char_addr[0] ? word[15:8] : word[7:0]. A byte toggle hits the cache without a new fetch.
  - scr_data = scroll cache word.
- A miss means the slot's ok is 0.
- FSM states: IDLE, WAIT_ACK, WAIT_DATA, plus a one-bit register `slot` recording which client is being served.
- IDLE:
  - Char miss has priority: latch pend_tag = char_addr[14:1], sdram_addr = CHAR_OFFSET + {8'd0, char_addr[14:1]}, slot=0.
  - Otherwise, on a scroll miss: pend_tag = scr_addr, sdram_addr = SCR_OFFSET + {5'd0, scr_addr}, slot=1.
  - On either: sdram_req=1, go to WAIT_ACK. With no miss, stay in IDLE.
- WAIT_ACK:
  - Hold sdram_req and sdram_addr.
  - On sdram_ack: sdram_req=0, go to WAIT_DATA.
  - If sdram_dst arrives in the same cycle as sdram_ack, treat it as WAIT_DATA completion and go straight to IDLE.
- WAIT_DATA:
  - On sdram_dst: write sdram_data into the slot's cache, tag = pend_tag, valid=1, go to IDLE.
  - Ignore sdram_dst in IDLE, and ignore it in WAIT_ACK unless sdram_ack is high in the same cycle.
- Latency:
  - Miss detected in IDLE at edge N: sdram_req is high after edge N.
  - Cache is written at the edge sampling sdram_dst; ok rises combinationally right after that edge.
  - A new miss is evaluated at the following edge (one IDLE cycle between fetches).
- Address change while a fetch is pending:
  - The fetch completes and fills the cache with pend_tag.
  - ok stays 0 because the tag does not match.
  - A new fetch is issued from IDLE. Requests are never aborted.
- Clearing of valid:
  - Cache valid only clears on reset.
  - ok drops in the same cycle the client's address moves to a different tag.
- Fairness: char strict priority. Starvation of scroll is acceptable because the char layer holds its address for at least 2 pxl_cen periods.
- Address arithmetic: 22-bit unsigned, wraps modulo 2^22. No overflow flag.
- Reset mid-fetch: return to IDLE and drop sdram_req asynchronously; a late sdram_dst after reset is ignored.

Test Plan:
- Reset then char_addr=15'h0004: expect sdram_req=1 with sdram_addr=22'h000002. Reply ack, then dst with 16'hBEEF two cycles later. Expect char_ok=1 and char_data=8'hEF. Change char_addr to 15'h0005: char_data=8'hBE, char_ok stays 1, no new sdram_req.
- scr_addr=17'h00010 and char_addr miss presented together: char served first (sdram_addr=22'h000000+tag); after its dst, one IDLE cycle, then sdram_req with sdram_addr=22'h008010.
- Change scr_addr from 17'h00010 to 17'h00011 between ack and dst of the first fetch: dst data is cached under tag 0x10 and scr_ok stays 0. A second request to 22'h008011 follows; scr_ok=1 after its dst.
- ack and dst in the same cycle: FSM goes straight to IDLE, the cache is filled, and ok rises immediately after that edge.
- Assert rstn=0 during WAIT_DATA, release, then pulse sdram_dst: expect sdram_req=0 asynchronously, char_ok=scr_ok=0, no cache write.
- SCR_OFFSET=22'h3FFFFF, scr_addr=17'h00002: expect sdram_addr=22'h000001 (wrap).
